// File: rtl/archer_projectile_ctrl.sv
// Archer projectile slot manager: spawns on accepted fire requests, moves live slots
// once per frame, retires them on range, screen edge or hit, and drives the packed draw bus.
module archer_projectile_ctrl #(
  parameter int unsigned PROJECTILE_COUNT = 4,
  parameter int unsigned PROJ_SPEED       = 8,
  parameter int unsigned MAX_RANGE        = 400,
  parameter int unsigned COOLDOWN_FRAMES  = 20,
  parameter int          X_MIN            = 0,
  parameter int          X_MAX            = 1023
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   frame_tick,
  input  logic                                   fire_req,
  output logic                                   fire_ack,
  input  logic [11:0]                            spawn_x,
  input  logic [11:0]                            spawn_y,
  input  logic                                   flip_hor_archer,
  input  logic [1:0]                             game_active,
  input  logic [1:0]                             char_class,
  input  logic                                   alive,
  input  logic [PROJECTILE_COUNT-1:0]            hit_clear,
  output logic [PROJECTILE_COUNT*12-1:0]         pos_x_proj,
  output logic [PROJECTILE_COUNT*12-1:0]         pos_y_proj,
  output logic [PROJECTILE_COUNT-1:0]            projectile_animated,
  output logic [PROJECTILE_COUNT-1:0]            proj_dir,
  output logic [$clog2(PROJECTILE_COUNT+1)-1:0]  active_count
);

  localparam int unsigned CNT_W = $clog2(PROJECTILE_COUNT + 1);
  localparam int unsigned CD_W  = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic signed [13:0] STEP   = 14'(PROJ_SPEED);
  localparam logic signed [13:0] XMIN_S = 14'(X_MIN);
  localparam logic signed [13:0] XMAX_S = 14'(X_MAX);
  localparam logic [10:0]        DSTEP  = 11'(PROJ_SPEED);
  localparam logic [10:0]        RANGE  = 11'(MAX_RANGE);

  typedef enum logic {FREE = 1'b0, FLYING = 1'b1} slot_state_e;

  slot_state_e               state_q [PROJECTILE_COUNT];
  slot_state_e               state_d [PROJECTILE_COUNT];
  logic [11:0]               x_q     [PROJECTILE_COUNT];
  logic [11:0]               x_d     [PROJECTILE_COUNT];
  logic [11:0]               y_q     [PROJECTILE_COUNT];
  logic [11:0]               y_d     [PROJECTILE_COUNT];
  logic [9:0]                dist_q  [PROJECTILE_COUNT];
  logic [9:0]                dist_d  [PROJECTILE_COUNT];
  logic [PROJECTILE_COUNT-1:0] dir_q, dir_d;
  logic [CD_W-1:0]           cd_q, cd_d;
  logic                      ack_q, ack_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic                      en, found, accept;
  int unsigned               tgt;
  logic signed [13:0]        xs, nx;
  logic [10:0]               ndist;

  always_comb begin
    en     = (game_active != 2'b00) && (char_class == 2'd2) && alive;
    found  = 1'b0;
    tgt    = 0;
    xs     = '0;
    nx     = '0;
    ndist  = '0;
    for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
      if (!found && state_q[i] == FREE) begin
        found = 1'b1;
        tgt   = i;
      end
    end
    accept = fire_req && en && (cd_q == '0) && found;
    ack_d  = accept;

    cd_d = cd_q;
    if (!en)                            cd_d = '0;
    else if (accept)                    cd_d = CD_W'(COOLDOWN_FRAMES);
    else if (frame_tick && cd_q != '0)  cd_d = cd_q - CD_W'(1);

    dir_d = dir_q;
    for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      dist_d[i]  = dist_q[i];
      // hit_clear only kills a flying slot, so a spawn into a free slot is never blocked by it
      if (!en || (hit_clear[i] && state_q[i] == FLYING)) begin
        state_d[i] = FREE;
        x_d[i]     = '0;
        y_d[i]     = '0;
        dist_d[i]  = '0;
        dir_d[i]   = 1'b0;
      end else if (accept && i == tgt) begin
        state_d[i] = FLYING;
        x_d[i]     = spawn_x;
        y_d[i]     = spawn_y;
        dist_d[i]  = '0;
        dir_d[i]   = flip_hor_archer;
      end else if (frame_tick && state_q[i] == FLYING) begin
        xs    = {2'b00, x_q[i]};
        nx    = dir_q[i] ? xs - STEP : xs + STEP;
        ndist = {1'b0, dist_q[i]} + DSTEP;
        if (nx < XMIN_S || nx > XMAX_S || ndist >= RANGE) begin
          state_d[i] = FREE;
          x_d[i]     = '0;
          y_d[i]     = '0;
          dist_d[i]  = '0;
          dir_d[i]   = 1'b0;
        end else begin
          x_d[i]    = nx[11:0];
          dist_d[i] = ndist[9:0];
        end
      end
    end

    cnt_d = '0;
    for (int unsigned i = 0; i < PROJECTILE_COUNT; i++)
      cnt_d = cnt_d + CNT_W'(state_d[i] == FLYING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
        state_q[i] <= FREE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        dist_q[i]  <= '0;
      end
      dir_q <= '0;
      cd_q  <= '0;
      ack_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        dist_q[i]  <= dist_d[i];
      end
      dir_q <= dir_d;
      cd_q  <= cd_d;
      ack_q <= ack_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pos_x_proj          = '0;
    pos_y_proj          = '0;
    projectile_animated = '0;
    for (int unsigned i = 0; i < PROJECTILE_COUNT; i++) begin
      pos_x_proj[i*12 +: 12] = x_q[i];
      pos_y_proj[i*12 +: 12] = y_q[i];
      projectile_animated[i] = (state_q[i] == FLYING);
    end
  end

  assign proj_dir     = dir_q;
  assign fire_ack     = ack_q;
  assign active_count = cnt_q;

endmodule
